// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port (IF) and a load/store port (DM).
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   if_req/if_addr         fetch request (held until if_valid)
//   if_valid/if_rdata      one-cycle fetch completion and fetched word
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_mode       load/store request (held until dm_valid)
//   dm_valid/dm_rdata      one-cycle data completion and load data
//   err                    timeout flag, meaningful with if_valid/dm_valid
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_mode     registered request to the memory
//   mem_ready/mem_rdata    memory completion and read data
//   stall                  combinational: some request still waiting for valid
//
// Each access walks IDLE -> BUSY -> RESP, so it takes at least three cycles.
// Ties in IDLE go to the port that did not win last time.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_mode,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mode,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned MODE_W = 3;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_WORD = 3'b010;

  // last_grant encoding; it also names the port owning the access in flight
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                grant_q,     grant_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [AW-1:0]       mem_addr_q,  mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [MODE_W-1:0]   mem_mode_q,  mem_mode_d;
  logic                if_valid_q,  if_valid_d;
  logic                dm_valid_q,  dm_valid_d;
  logic [DW-1:0]       if_rdata_q,  if_rdata_d;
  logic [DW-1:0]       dm_rdata_q,  dm_rdata_d;
  logic                err_q,       err_d;

  // Completion of the access in flight (normal or aborted)
  logic                resp_fire_c;
  logic                resp_err_c;
  logic [DW-1:0]       resp_data_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= GRANT_DM;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    resp_fire_c = 1'b0;
    resp_err_c  = 1'b0;
    resp_data_c = '0;

    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          // Tie goes to whoever lost last time; a lone requester simply wins
          if (if_req && dm_req) begin
            grant_d = ~grant_q;
          end else begin
            grant_d = dm_req ? GRANT_DM : GRANT_IF;
          end

          if (grant_d == GRANT_DM) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_mode_d  = dm_mode;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_mode_d  = MODE_WORD;
          end

          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end
      end

      S_BUSY: begin
        // mem_ready wins over a timeout landing in the same cycle
        if (mem_ready) begin
          resp_fire_c = 1'b1;
          resp_err_c  = 1'b0;
          resp_data_c = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          resp_fire_c = 1'b1;
          resp_err_c  = 1'b1;
          resp_data_c = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        // valid is high this cycle; requests are not looked at until IDLE
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retire the access: drop the memory request and notify the owner
    if (resp_fire_c) begin
      mem_req_d = 1'b0;
      err_d     = resp_err_c;
      state_d   = S_RESP;
      if (grant_q == GRANT_DM) begin
        dm_rdata_d = resp_data_c;
        dm_valid_d = 1'b1;
      end else begin
        if_rdata_d = resp_data_c;
        if_valid_d = 1'b1;
      end
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mode  = mem_mode_q;

  // Pipeline freeze while either port is still waiting for its completion
  assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: max cycles an access waits for mem_ready before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_valid  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  fetched word, valid with if_valid.
REQ-008 SHALL have port dm_req  input  1  load/store request, held until dm_valid.
REQ-009 SHALL have port dm_we  input  1  1=store, 0=load.
REQ-010 SHALL have port dm_addr  input  32  data byte address.
REQ-011 SHALL have port dm_wdata  input  32  store data.
REQ-012 SHALL have port dm_mode  input  3  access mode (funct3 encoding: byte/half/word, signed/unsigned).
REQ-013 SHALL have port dm_valid  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port dm_rdata  output  32  load data, valid with dm_valid.
REQ-015 SHALL have port err  output  1  timeout flag, valid with if_valid/dm_valid.
REQ-016 SHALL have ports mem_req/mem_we (1), mem_addr/mem_wdata (32), mem_mode (3)  output  registered request to single-ported memory.
REQ-017 SHALL have ports mem_ready (1), mem_rdata (32)  input  memory completion and read data.
REQ-018 SHALL have port stall  output  1  freezes PC/pipeline while any request is pending.

Function
REQ-019 SHALL implement FSM IDLE, BUSY, RESP, plus last_grant bit (IF/DM) and timeout counter.
REQ-020 IDLE, one request high: SHALL grant it, latch its addr/we/wdata/mode (fetch: we=0, mode=word) into mem_* and go BUSY; mem_req=1 next cycle.
REQ-021 IDLE, both high: SHALL grant the requester not in last_grant; update last_grant to the winner.
REQ-022 BUSY: mem_req SHALL stay 1 with stable mem_* until mem_ready=1; counter increments each BUSY cycle.
REQ-023 BUSY with mem_ready=1: SHALL register mem_rdata into granted port's rdata, set err=0, mem_req=0, go RESP.
REQ-024 BUSY with counter reaching TIMEOUT_CYC-1 and mem_ready=0: SHALL abort, mem_req=0, rdata=0, err=1, go RESP.
REQ-025 mem_ready and timeout in the same cycle: SHALL take mem_ready (normal completion).
REQ-026 RESP: SHALL pulse granted port's valid for exactly one cycle, clear counter, go IDLE; requests ignored in RESP.
REQ-027 Latency: req in IDLE cycle N, mem_ready in cycle N+k (k>=1) -> valid in cycle N+k+1; minimum 3 cycles per access.
REQ-028 Non-granted requester SHALL wait with no valid, no side effects; both requests always eventually served (no starvation).
REQ-029 rdata/err SHALL hold last value outside valid; mem_ready outside BUSY SHALL be ignored.
REQ-030 stall SHALL equal (if_req & ~if_valid) | (dm_req & ~dm_valid), combinational.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, mem_req=0, if_valid=dm_valid=0, err=0, counter=0, rdata=0, mem_*=0, last_grant=DM (first tie goes to fetch).
REQ-032 Reset mid-BUSY SHALL abandon the access; no valid issued for it after release.

Verification
REQ-033 Fetch only, if_addr=0x10, mem_ready 2 cycles after mem_req, mem_rdata=0x00500093 -> if_valid one cycle later, if_rdata=0x00500093, err=0.
REQ-034 if_req and dm_req rise together after reset -> fetch served first, then store (dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_mode=010) with mem_we=1; dm_valid after.
REQ-035 Both held continuously for 6 accesses -> grants alternate IF,DM,IF,DM,IF,DM.
REQ-036 mem_ready held 0 -> mem_req drops after 16 BUSY cycles, valid with err=1, rdata=0.
REQ-037 rst=0 asserted during BUSY -> mem_req=0 same cycle; after release no stale valid; new fetch completes normally.
REQ-038 mem_ready on final timeout cycle -> normal completion, err=0, rdata=mem_rdata.
